// File: rtl/mem_stage.sv
// mem_stage: memory-access stage driving a req/gnt/rvalid data bus and
// registering the selected write-back value toward MEM/WB.
module mem_stage #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mem_reg_write_i,
  input  logic [1:0]    mem_mem_write_i,
  input  logic [1:0]    mem_size_i,
  input  logic          mem_unsigned_i,
  input  logic          mem_reg_we_i,
  input  logic [31:0]   mem_resC_i,
  input  logic [DW-1:0] mem_rD2_i,
  input  logic [DW-1:0] mem_ext_i,
  input  logic [DW-1:0] mem_pc4_i,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [AW-1:0] dbus_addr_o,
  output logic [3:0]    dbus_be_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_gnt_i,
  input  logic          dbus_rvalid_i,
  input  logic [DW-1:0] dbus_rdata_i,
  output logic          stall_o,
  output logic          wb_valid_o,
  output logic          wb_reg_we_o,
  output logic [DW-1:0] wb_data_o,
  output logic          misalign_o
);
  typedef enum logic {IDLE, WAIT_R} state_t;
  state_t state, state_nx;
  logic ld, st, access, aligned, misalign, go, done;
  logic [DW-1:0] lane, load_val, sel_val;
  always_comb begin
    ld = mem_mem_write_i == 2'b10;
    st = mem_mem_write_i == 2'b01;
    access = ld | st;
    aligned = mem_size_i == 2'b00 ? 1'b1 :
              mem_size_i == 2'b01 ? ~mem_resC_i[0] : mem_resC_i[1:0] == 2'b00;
    misalign = access & ~aligned;
    go = access & aligned & ~rst;
    done = (state == IDLE & st & dbus_gnt_i) | (state == WAIT_R & dbus_rvalid_i);
    dbus_req_o = go & (state == IDLE);
    dbus_we_o = st;
    stall_o = go & ~done;
    state_nx = state == IDLE ? ((dbus_req_o & ld & dbus_gnt_i) ? WAIT_R : IDLE) :
               (dbus_rvalid_i ? IDLE : WAIT_R);
    dbus_addr_o = {mem_resC_i[AW-1:2], 2'b00};
    dbus_be_o = mem_size_i == 2'b00 ? 4'b0001 << mem_resC_i[1:0] :
                mem_size_i == 2'b01 ? 4'b0011 << mem_resC_i[1:0] : 4'b1111;
    dbus_wdata_o = mem_size_i == 2'b00 ? {4{mem_rD2_i[7:0]}} :
                   mem_size_i == 2'b01 ? {2{mem_rD2_i[15:0]}} : mem_rD2_i;
    lane = dbus_rdata_i >> {mem_resC_i[1:0], 3'b000};
    load_val = mem_size_i == 2'b00 ? {{24{~mem_unsigned_i & lane[7]}}, lane[7:0]} :
               mem_size_i == 2'b01 ? {{16{~mem_unsigned_i & lane[15]}}, lane[15:0]} : lane;
    // load data only exists in the cycle rvalid completes the access
    sel_val = mem_reg_write_i == 2'b00 ? mem_resC_i :
              mem_reg_write_i == 2'b01 ? ((state == WAIT_R & dbus_rvalid_i) ? load_val : '0) :
              mem_reg_write_i == 2'b10 ? mem_pc4_i : mem_ext_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wb_valid_o <= 1'b0;
      wb_reg_we_o <= 1'b0;
      wb_data_o <= '0;
      misalign_o <= 1'b0;
    end else begin
      state <= state_nx;
      misalign_o <= misalign;
      if (stall_o) begin
        wb_valid_o <= 1'b0;
        wb_reg_we_o <= 1'b0;
      end else begin
        wb_valid_o <= mem_reg_we_i | access;
        wb_reg_we_o <= mem_reg_we_i & ~misalign;
        wb_data_o <= sel_val;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected write-back results are
// queued as each op is driven and compared after the following clock edge.
module tb_mem_stage;
  logic clk = 0, rst = 1;
  logic [1:0] sel = 0, mw = 0, size = 0;
  logic uns = 0, we = 0;
  logic [31:0] resc = 0, rd2 = 0, ext = 0, pc4 = 0, rdata = 0;
  logic gnt = 0, rvalid = 0;
  logic req, bwe, stall, wb_valid, wb_we, mis;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0] be;
  int total = 0, bad = 0;
  logic [31:0] last_d = 0;
  typedef struct { logic v; logic w; logic [31:0] d; logic m; } exp_t;
  exp_t sb[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .mem_reg_write_i(sel), .mem_mem_write_i(mw),
    .mem_size_i(size), .mem_unsigned_i(uns), .mem_reg_we_i(we),
    .mem_resC_i(resc), .mem_rD2_i(rd2), .mem_ext_i(ext), .mem_pc4_i(pc4),
    .dbus_req_o(req), .dbus_we_o(bwe), .dbus_addr_o(addr), .dbus_be_o(be),
    .dbus_wdata_o(wdata), .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid),
    .dbus_rdata_i(rdata), .stall_o(stall), .wb_valid_o(wb_valid),
    .wb_reg_we_o(wb_we), .wb_data_o(wb_data), .misalign_o(mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [1:0] s, input logic [1:0] m, input logic [1:0] z,
                    input logic u, input logic w, input logic [31:0] r);
    sel = s; mw = m; size = z; uns = u; we = w; resc = r;
  endtask

  task automatic push(input logic v, input logic w, input logic [31:0] d, input logic m);
    exp_t e;
    e.v = v; e.w = w; e.d = d; e.m = m;
    sb.push_back(e);
    last_d = d;
  endtask

  task automatic bubble();
    push(1'b0, 1'b0, last_d, 1'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("wb_valid", {31'b0, wb_valid}, {31'b0, e.v});
      check("wb_we", {31'b0, wb_we}, {31'b0, e.w});
      check("wb_data", wb_data, e.d);
      check("misalign", {31'b0, mis}, {31'b0, e.m});
    end
  endtask

  task automatic comb(input logic r, input logic s);
    #1;
    check("req", {31'b0, req}, {31'b0, r});
    check("stall", {31'b0, stall}, {31'b0, s});
  endtask

  task automatic load(input logic [1:0] z, input logic u, input logic [31:0] a,
                      input logic [31:0] data, input logic [3:0] exp_be, input logic [31:0] exp_d);
    op(2'b01, 2'b10, z, u, 1'b1, a);
    gnt = 1;
    comb(1'b1, 1'b1);
    check("ld_be", {28'b0, be}, {28'b0, exp_be});
    check("ld_we", {31'b0, bwe}, 32'd0);
    check("ld_addr", addr, {a[31:2], 2'b00});
    bubble(); tick();
    gnt = 0;
    comb(1'b0, 1'b1);
    bubble(); tick();
    rvalid = 1; rdata = data;
    comb(1'b0, 1'b0);
    push(1'b1, 1'b1, exp_d, 1'b0); tick();
    rvalid = 0;
  endtask

  initial begin
    op(2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 32'h100);
    gnt = 1;
    comb(1'b0, 1'b0);
    push(1'b0, 1'b0, 32'h0, 1'b0); tick();
    gnt = 0; rst = 0;
    op(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 32'h1234);
    comb(1'b0, 1'b0);
    push(1'b1, 1'b1, 32'h1234, 1'b0); tick();
    load(2'b00, 1'b0, 32'h103, 32'h80FF_1122, 4'b1000, 32'hFFFF_FF80);
    load(2'b00, 1'b1, 32'h103, 32'h80FF_1122, 4'b1000, 32'h0000_0080);
    load(2'b01, 1'b0, 32'h102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    load(2'b10, 1'b0, 32'h204, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    op(2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 32'h102);
    rd2 = 32'h0000_ABCD;
    for (int i = 0; i < 3; i++) begin
      comb(1'b1, 1'b1);
      check("sh_be", {28'b0, be}, 32'hC);
      check("sh_wdata", wdata, 32'hABCD_ABCD);
      check("sh_we", {31'b0, bwe}, 32'd1);
      bubble(); tick();
    end
    gnt = 1;
    comb(1'b1, 1'b0);
    push(1'b1, 1'b0, 32'h102, 1'b0); tick();
    gnt = 0;
    op(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'h301);
    rd2 = 32'h1234_565A;
    gnt = 1;
    comb(1'b1, 1'b0);
    check("sb_be", {28'b0, be}, 32'h2);
    check("sb_wdata", wdata, 32'h5A5A_5A5A);
    push(1'b1, 1'b0, 32'h301, 1'b0); tick();
    gnt = 0;
    op(2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 32'h101);
    comb(1'b0, 1'b0);
    push(1'b1, 1'b0, 32'h0, 1'b1); tick();
    op(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    comb(1'b0, 1'b0);
    push(1'b0, 1'b0, 32'h0, 1'b0); tick();
    op(2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 32'h200);
    gnt = 1;
    comb(1'b1, 1'b1);
    bubble(); tick();
    gnt = 0; rst = 1;
    comb(1'b0, 1'b0);
    push(1'b0, 1'b0, 32'h0, 1'b0); tick();
    rst = 0;
    op(2'b01, 2'b00, 2'b10, 1'b0, 1'b1, 32'h0);
    rvalid = 1; rdata = 32'hCAFE_F00D;
    comb(1'b0, 1'b0);
    push(1'b1, 1'b1, 32'h0, 1'b0); tick();
    rvalid = 0;
    op(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 32'h55);
    pc4 = 32'h40;
    comb(1'b0, 1'b0);
    push(1'b1, 1'b1, 32'h40, 1'b0); tick();
    op(2'b11, 2'b00, 2'b10, 1'b0, 1'b1, 32'h55);
    ext = 32'hFFFF_FFF0;
    comb(1'b0, 1'b0);
    push(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0); tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
